room_thermal_model: RTL and testbench

Cycle-based thermal plant model that closes the loop with the air-conditioning controller. It consumes the controller's `heating`/`cooling` commands and produces the 5-bit room `temperature` that feeds back into the controller. Heating raises the temperature, cooling lowers it, and with neither active the room drifts toward an ambient value. It is used in closed-loop simulation and on-board demo builds.

---
 rtl/thermal_pkg.sv | 20 ++
 rtl/step_timer.sv | 28 ++
 rtl/room_thermal_model.sv | 89 ++++++++
 tb/tb_room_thermal_model.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/thermal_pkg.sv
// Shared constants and saturating arithmetic for the room thermal model and its controller.
package thermal_pkg;

    localparam int unsigned     TEMP_W   = 5;
    localparam logic [TEMP_W-1:0] TEMP_MAX = 5'd31;

    // Mode encoding is {heating, cooling}
    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_HEAT  = 2'b10;
    localparam logic [1:0] MODE_COOL  = 2'b01;
    localparam logic [1:0] MODE_FAULT = 2'b11;

    function automatic logic [TEMP_W-1:0] sat_step(input logic [TEMP_W-1:0] t, input logic up);
        if (up)
            return (t == TEMP_MAX) ? t : t + TEMP_W'(1);
        else
            return (t == '0) ? t : t - TEMP_W'(1);
    endfunction

endpackage

// File: rtl/step_timer.sv
// Free-running period counter; tick marks the last cycle of each period.
module step_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             hold,
    input  logic [CNT_W-1:0] period,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic             at_end;

    assign at_end = (cnt == period - CNT_W'(1));
    assign tick   = at_end && !restart && !hold;

    always_ff @(posedge clk) begin
        if (rst || restart || hold)
            cnt <= '0;
        else if (at_end)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/room_thermal_model.sv
// Closed-loop room plant: heating/cooling commands step the temperature, idle drifts to ambient.
module room_thermal_model
    import thermal_pkg::*;
#(
    parameter int unsigned T_INIT       = 20,
    parameter int unsigned AMBIENT      = 15,
    parameter int unsigned HEAT_PERIOD  = 4,
    parameter int unsigned COOL_PERIOD  = 4,
    parameter int unsigned DRIFT_PERIOD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              heating,
    input  logic              cooling,
    output logic [TEMP_W-1:0] temperature,
    output logic              temp_change,
    output logic              fault
);

    localparam int unsigned MAX_HC = (HEAT_PERIOD > COOL_PERIOD) ? HEAT_PERIOD : COOL_PERIOD;
    localparam int unsigned MAX_P  = (MAX_HC > DRIFT_PERIOD) ? MAX_HC : DRIFT_PERIOD;
    localparam int unsigned CNT_W  = $clog2(MAX_P + 1);

    localparam logic [TEMP_W-1:0] T_INIT_T  = TEMP_W'(T_INIT);
    localparam logic [TEMP_W-1:0] AMBIENT_T = TEMP_W'(AMBIENT);

    logic [1:0]        mode_d;
    logic [1:0]        mode_q;
    logic [CNT_W-1:0]  period;
    logic [TEMP_W-1:0] stepped;
    logic              tick;

    assign mode_d = {heating, cooling};

    always_comb begin
        period = CNT_W'(DRIFT_PERIOD);
        case (mode_q)
            MODE_HEAT: period = CNT_W'(HEAT_PERIOD);
            MODE_COOL: period = CNT_W'(COOL_PERIOD);
            default:   period = CNT_W'(DRIFT_PERIOD);
        endcase
    end

    // A mode change restarts the count; a sustained fault parks it at zero.
    step_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (mode_d != mode_q),
        .hold    (mode_d == MODE_FAULT),
        .period  (period),
        .tick    (tick)
    );

    always_comb begin
        stepped = temperature;
        case (mode_q)
            MODE_HEAT: stepped = sat_step(temperature, 1'b1);
            MODE_COOL: stepped = sat_step(temperature, 1'b0);
            MODE_IDLE: begin
                if (temperature < AMBIENT_T)
                    stepped = sat_step(temperature, 1'b1);
                else if (temperature > AMBIENT_T)
                    stepped = sat_step(temperature, 1'b0);
            end
            default: stepped = temperature;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            temperature <= T_INIT_T;
            mode_q      <= MODE_IDLE;
            temp_change <= 1'b0;
            fault       <= 1'b0;
        end else begin
            mode_q <= mode_d;
            fault  <= (mode_d == MODE_FAULT);
            if (tick) begin
                temperature <= stepped;
                temp_change <= (stepped != temperature);
            end else begin
                temp_change <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_room_thermal_model.sv
// Randomized and directed bench for room_thermal_model against a run-length behavioural model.
module tb_room_thermal_model;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       heating = 1'b0;
    logic       cooling = 1'b0;
    logic [4:0] temp0, temp1;
    logic       chg0, chg1, flt0, flt1;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    room_thermal_model u_dut0 (
        .clk(clk), .rst(rst), .heating(heating), .cooling(cooling),
        .temperature(temp0), .temp_change(chg0), .fault(flt0)
    );

    room_thermal_model #(
        .T_INIT(2), .AMBIENT(25), .HEAT_PERIOD(3), .COOL_PERIOD(4), .DRIFT_PERIOD(5)
    ) u_dut1 (
        .clk(clk), .rst(rst), .heating(heating), .cooling(cooling),
        .temperature(temp1), .temp_change(chg1), .fault(flt1)
    );

    int unsigned p_tinit[2] = '{20, 2};
    int unsigned p_amb[2]   = '{15, 25};
    int unsigned p_heat[2]  = '{4, 3};
    int unsigned p_cool[2]  = '{4, 4};
    int unsigned p_drift[2] = '{8, 5};

    // Model: count consecutive edges the same command has been held; step on multiples of the period.
    int unsigned m_temp[2];
    int unsigned m_run[2];
    int          m_mode[2];
    bit          m_pulse[2];
    bit          m_fault[2];

    always @(posedge clk) begin
        int mode;
        int unsigned per, nt;
        mode = heating * 2 + cooling;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_temp[i] = p_tinit[i]; m_run[i] = 0; m_mode[i] = 0;
                m_pulse[i] = 0; m_fault[i] = 0;
            end else begin
                m_fault[i] = (mode == 3);
                m_pulse[i] = 0;
                if (mode != m_mode[i]) begin
                    m_mode[i] = mode;
                    m_run[i]  = 0;
                end else if (mode != 3) begin
                    m_run[i]++;
                    per = (mode == 2) ? p_heat[i] : (mode == 1) ? p_cool[i] : p_drift[i];
                    if (m_run[i] % per == 0) begin
                        nt = m_temp[i];
                        if (mode == 2) nt = (nt < 31) ? nt + 1 : 31;
                        else if (mode == 1) nt = (nt > 0) ? nt - 1 : 0;
                        else if (nt < p_amb[i]) nt = nt + 1;
                        else if (nt > p_amb[i]) nt = nt - 1;
                        m_pulse[i] = (nt != m_temp[i]);
                        m_temp[i]  = nt;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("temp0", int'(temp0), int'(m_temp[0]));
            chk("chg0",  int'(chg0),  int'(m_pulse[0]));
            chk("flt0",  int'(flt0),  int'(m_fault[0]));
            chk("temp1", int'(temp1), int'(m_temp[1]));
            chk("chg1",  int'(chg1),  int'(m_pulse[1]));
            chk("flt1",  int'(flt1),  int'(m_fault[1]));
        end
    end

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic h, input logic c);
        @(negedge clk);
        rst = 1'b1; heating = 1'b0; cooling = 1'b0;
        edges(2);
        rst = 1'b0; heating = h; cooling = c;
    endtask

    initial begin
        edges(2);
        rst = 1'b0;
        edges(1);
        rst = 1'b1;
        edges(1);
        checking = 1'b1;
        chk("reset_temp0", int'(temp0), 20);
        chk("reset_temp1", int'(temp1), 2);
        chk("reset_flt", int'(flt0), 0);
        chk("reset_chg", int'(chg0), 0);

        // Idle drift from 20 toward 15
        do_reset(1'b0, 1'b0);
        edges(7);
        chk("idle_e7", int'(temp0), 20);
        edges(1);
        chk("idle_e8", int'(temp0), 19);
        chk("idle_e8_pulse", int'(chg0), 1);
        edges(8);
        chk("idle_e16", int'(temp0), 18);
        edges(100);
        chk("idle_settled", int'(temp0), 15);

        // Heating to saturation
        do_reset(1'b1, 1'b0);
        edges(5);
        chk("heat_e4", int'(temp0), 21);
        edges(4);
        chk("heat_e8", int'(temp0), 22);
        edges(45);
        chk("heat_top", int'(temp0), 31);
        edges(40);
        chk("heat_hold", int'(temp0), 31);

        // Cooling from T_INIT=2 (second instance)
        do_reset(1'b0, 1'b1);
        edges(5);
        chk("cool_e4", int'(temp1), 1);
        edges(4);
        chk("cool_e8", int'(temp1), 0);
        edges(20);
        chk("cool_floor", int'(temp1), 0);

        // Fault then heat
        do_reset(1'b1, 1'b1);
        edges(1);
        chk("fault_first", int'(flt0), 1);
        edges(9);
        chk("fault_held_temp", int'(temp0), 20);
        cooling = 1'b0;
        edges(1);
        chk("fault_clear", int'(flt0), 0);
        edges(4);
        chk("fault_then_heat", int'(temp0), 21);

        // Fast toggling never steps
        do_reset(1'b1, 1'b0);
        for (int k = 0; k < 12; k++) begin
            edges(3);
            heating = ~heating;
        end
        chk("toggle_no_move", int'(temp0), 20);

        // Reset mid-count restarts from zero
        edges(1);
        heating = 1'b1;
        edges(3);
        rst = 1'b1;
        edges(1);
        rst = 1'b0;
        edges(4);
        chk("rst_mid_e4", int'(temp0), 20);
        edges(1);
        chk("rst_mid_e5", int'(temp0), 21);

        // Randomized closed-loop-like stimulus
        for (int k = 0; k < 400; k++) begin
            int unsigned m, len;
            m   = $urandom_range(0, 3);
            len = $urandom_range(1, 14);
            heating = m[1];
            cooling = m[0];
            rst = ($urandom_range(0, 40) == 0);
            edges(1);
            rst = 1'b0;
            edges(int'(len));
        end

        edges(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
